led_breathe: RTL and testbench

- Consumer stage directly downstream of the 16 MHz prescaler.
- Takes one prescaler output bit and uses it as a time base, without clocking any logic from it.
- Generates a PWM "breathing" LED drive whose duty ramps up and down in fixed steps.
- Exposes a per-step tick and the current duty for other demo logic.

---
 rtl/led_breathe_pkg.sv | 15 +
 rtl/led_breathe_rise_edge_det.sv | 39 +++
 rtl/led_breathe.sv | 127 ++++++++++++
 tb/tb_led_breathe.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_breathe_pkg.sv
// rtl/led_breathe_pkg.sv - shared FSM state encoding and duty-range helper for led_breathe
package led_breathe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2
    } state_t;

    // Largest duty value for a given PWM width (all ones).
    function automatic int duty_max(input int bits);
        return (1 << bits) - 1;
    endfunction

endpackage

// File: rtl/led_breathe_rise_edge_det.sv
// rtl/led_breathe_rise_edge_det.sv - single-cycle rising-edge detector on a data-sampled prescaler bit
// Optional 2-flop input synchroniser enabled by LED_BREATHE_SYNC_EN.
module rise_edge_det (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic sig_i,
    output logic edge_o
);

    logic w_sig;
    logic r_q;

`ifdef LED_BREATHE_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], sig_i};
        end
    end

    assign w_sig = r_sync[1];
`else
    assign w_sig = sig_i;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_q <= 1'b0;
        end else begin
            r_q <= w_sig;
        end
    end

    assign edge_o = w_sig & ~r_q;

endmodule

// File: rtl/led_breathe.sv
// rtl/led_breathe.sv - PWM breathing LED driven from a prescaler bit used as a data-rate time base
// Define LED_BREATHE_SYNC_EN to synchronise an asynchronous prescaler input (adds 2 cycles latency).
module led_breathe
    import led_breathe_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int PWM_BITS = 8,
    parameter int STEP     = 1
) (
    input  logic                clk_16mhz_i,
    input  logic                rstn_i,
    input  logic                presc_clk_i,
    input  logic                enable_i,
    output logic                led_o,
    output logic                tick_o,
    output logic [PWM_BITS-1:0] duty_o,
    output logic                dir_o
);

    localparam int                  SC_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [SC_W-1:0]     SC_LAST  = SC_W'(TICK_DIV - 1);
    localparam logic [SC_W-1:0]     SC_ONE   = SC_W'(1);
    localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
    localparam logic [PWM_BITS:0]   DUTY_MAX = (PWM_BITS + 1)'(duty_max(PWM_BITS));
    localparam logic [PWM_BITS:0]   STEP_W   = (PWM_BITS + 1)'(STEP);

    state_t              r_state, w_state_nxt;
    logic [PWM_BITS-1:0] r_duty, w_duty_nxt;
    logic [PWM_BITS-1:0] r_pwm_cnt, w_pwm_nxt;
    logic [SC_W-1:0]     r_step_cnt, w_step_cnt_nxt;
    logic                r_led, w_led_nxt;
    logic                r_tick, w_tick_nxt;
    logic                w_edge;
    logic                w_step;
    logic [PWM_BITS:0]   w_sum;

    rise_edge_det u_edge (
        .clk_i  (clk_16mhz_i),
        .rstn_i (rstn_i),
        .sig_i  (presc_clk_i),
        .edge_o (w_edge)
    );

    assign w_step = w_edge && (r_step_cnt == SC_LAST);
    // Widened sum so saturation at the top never wraps.
    assign w_sum  = {1'b0, r_duty} + STEP_W;

    always_ff @(posedge clk_16mhz_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= IDLE;
            r_duty     <= '0;
            r_pwm_cnt  <= '0;
            r_step_cnt <= '0;
            r_led      <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_duty     <= w_duty_nxt;
            r_pwm_cnt  <= w_pwm_nxt;
            r_step_cnt <= w_step_cnt_nxt;
            r_led      <= w_led_nxt;
            r_tick     <= w_tick_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_duty_nxt     = r_duty;
        w_pwm_nxt      = r_pwm_cnt;
        w_step_cnt_nxt = r_step_cnt;
        w_tick_nxt     = 1'b0;
        w_led_nxt      = (r_state != IDLE) && (r_pwm_cnt < r_duty);

        if (!enable_i) begin
            // Disable dominates any coincident step.
            w_state_nxt    = IDLE;
            w_duty_nxt     = '0;
            w_pwm_nxt      = '0;
            w_step_cnt_nxt = '0;
            w_led_nxt      = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt    = RISE;
                    w_duty_nxt     = '0;
                    w_pwm_nxt      = '0;
                    w_step_cnt_nxt = '0;
                end
                RISE, FALL: begin
                    if (w_edge) begin
                        w_pwm_nxt = r_pwm_cnt + PWM_ONE;
                        if (w_step) begin
                            w_step_cnt_nxt = '0;
                            w_tick_nxt     = 1'b1;
                            if (r_state == RISE) begin
                                if (w_sum >= DUTY_MAX) begin
                                    w_duty_nxt  = DUTY_MAX[PWM_BITS-1:0];
                                    w_state_nxt = FALL;
                                end else begin
                                    w_duty_nxt = w_sum[PWM_BITS-1:0];
                                end
                            end else begin
                                if ({1'b0, r_duty} <= STEP_W) begin
                                    w_duty_nxt  = '0;
                                    w_state_nxt = RISE;
                                end else begin
                                    w_duty_nxt = r_duty - STEP_W[PWM_BITS-1:0];
                                end
                            end
                        end else begin
                            w_step_cnt_nxt = r_step_cnt + SC_ONE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign led_o  = r_led;
    assign tick_o = r_tick;
    assign duty_o = r_duty;
    assign dir_o  = (r_state == RISE);

endmodule

// File: tb/tb_led_breathe.sv
// tb/tb_led_breathe.sv - self-checking bench for led_breathe with a triangle-wave reference model
module tb_led_breathe;

    localparam int TD   = 4;
    localparam int ST   = 4;
    localparam int MAXD = 15;
    localparam int PER  = 16;

    logic       clk   = 1'b0;
    logic       rstn  = 1'b0;
    logic       presc = 1'b0;
    logic       en    = 1'b0;
    logic       led, tick, dir;
    logic [3:0] duty;
    logic       s_led, s_tick, s_dir;
    logic [3:0] s_duty;

    always #5 clk = ~clk;

    led_breathe #(.TICK_DIV(TD), .PWM_BITS(4), .STEP(ST)) u_dut (
        .clk_16mhz_i (clk),
        .rstn_i      (rstn),
        .presc_clk_i (presc),
        .enable_i    (en),
        .led_o       (led),
        .tick_o      (tick),
        .duty_o      (duty),
        .dir_o       (dir)
    );

    led_breathe #(.TICK_DIV(1000), .PWM_BITS(4), .STEP(ST)) u_slow (
        .clk_16mhz_i (clk),
        .rstn_i      (rstn),
        .presc_clk_i (presc),
        .enable_i    (en),
        .led_o       (s_led),
        .tick_o      (s_tick),
        .duty_o      (s_duty),
        .dir_o       (s_dir)
    );

    typedef struct {
        int duty;
        int dir;
    } ramp_vec_t;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int tri_duty[$];
    int tri_dir[$];
    int tick_cyc[$];
    int cyc = 0;
    int ph  = 0;

    bit m_q, m_d1, m_d2, m_run, m_led, m_tick;
    int m_n;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: the breathing waveform is a periodic triangle indexed by completed steps.
    function automatic int exp_duty();
        return m_run ? tri_duty[(m_n / TD) % tri_duty.size()] : 0;
    endfunction

    function automatic int exp_dir();
        return m_run ? tri_dir[(m_n / TD) % tri_dir.size()] : 0;
    endfunction

    function automatic bit pipe_out(input bit p);
`ifdef LED_BREATHE_SYNC_EN
        return m_d2;
`else
        return p;
`endif
    endfunction

    function automatic bit edge_next(input bit p);
        return pipe_out(p) & ~m_q;
    endfunction

    task automatic model_reset();
        m_q = 0; m_d1 = 0; m_d2 = 0; m_run = 0; m_led = 0; m_tick = 0; m_n = 0;
    endtask

    task automatic model_step(input bit p, input bit e);
        bit ed;
        bit led_new;
        ed      = edge_next(p);
        led_new = m_run && ((m_n % PER) < exp_duty());
        m_q     = pipe_out(p);
`ifdef LED_BREATHE_SYNC_EN
        m_d2 = m_d1;
        m_d1 = p;
`endif
        if (!e) begin
            m_run = 0; m_n = 0; m_led = 0; m_tick = 0;
        end else if (!m_run) begin
            m_run = 1; m_n = 0; m_led = 0; m_tick = 0;
        end else begin
            m_led  = led_new;
            m_tick = 0;
            if (ed) begin
                m_n++;
                m_tick = ((m_n % TD) == 0);
            end
        end
    endtask

    task automatic cycle(input bit p, input bit e);
        @(negedge clk);
        chk("led",  int'(led),  int'(m_led));
        chk("tick", int'(tick), int'(m_tick));
        chk("duty", int'(duty), exp_duty());
        chk("dir",  int'(dir),  exp_dir());
        if (tick) tick_cyc.push_back(cyc);
        cyc++;
        presc = p;
        en    = e;
        model_step(p, e);
    endtask

    task automatic mhz(input bit e);
        cycle(((ph % 16) < 8), e);
        ph++;
    endtask

    task automatic wait_tick(input string name);
        bit seen;
        seen = 0;
        for (int k = 0; k < 200; k++) begin
            mhz(1);
            if (tick) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ramp_vec_t vec[10];
        int d, dr, cnt;
        bit p, found;

        d = 0; dr = 1;
        tri_duty.push_back(0); tri_dir.push_back(1);
        for (int k = 0; k < 1000; k++) begin
            if (dr != 0) begin
                if (d + ST >= MAXD) begin d = MAXD; dr = 0; end
                else d += ST;
            end else begin
                if (d <= ST) begin d = 0; dr = 1; end
                else d -= ST;
            end
            if (d == 0 && dr == 1) break;
            tri_duty.push_back(d); tri_dir.push_back(dr);
        end

        vec[0] = '{0, 1};  vec[1] = '{4, 1};  vec[2] = '{8, 1};  vec[3] = '{12, 1};
        vec[4] = '{15, 0}; vec[5] = '{11, 0}; vec[6] = '{7, 0};  vec[7] = '{3, 0};
        vec[8] = '{0, 1};  vec[9] = '{4, 1};

        model_reset();
        repeat (3) cycle(0, 0);
        chk("rst_led",   int'(led),  0);
        chk("rst_tick",  int'(tick), 0);
        chk("rst_duty",  int'(duty), 0);
        chk("rst_dir",   int'(dir),  0);
        chk("rst_state", int'(u_dut.r_state), 0);
        rstn = 1'b1;
        repeat (4) mhz(0);

        // Ramp and saturation through one full triangle period and back up.
        mhz(1);
        mhz(1);
        chk("ramp_duty_0", int'(duty), vec[0].duty);
        chk("ramp_dir_0",  int'(dir),  vec[0].dir);
        tick_cyc.delete();
        for (int i = 1; i < 10; i++) begin
            wait_tick($sformatf("ramp_%0d", i));
            chk($sformatf("ramp_duty_%0d", i), int'(duty), vec[i].duty);
            chk($sformatf("ramp_dir_%0d", i),  int'(dir),  vec[i].dir);
        end
        chk("tick_count", tick_cyc.size(), 9);
        for (int i = 1; i < tick_cyc.size(); i++)
            chk($sformatf("tick_gap_%0d", i), tick_cyc[i] - tick_cyc[i-1], TD * 16);

        // Disable on the very clock that would produce a step.
        found = 0;
        for (int k = 0; k < 200; k++) begin
            p = ((ph % 16) < 8);
            if (m_run && edge_next(p) && (((m_n + 1) % TD) == 0)) begin
                cycle(p, 0);
                ph++;
                found = 1;
                break;
            end
            mhz(1);
        end
        chk("dis_found", int'(found), 1);
        mhz(0);
        chk("dis_tick", int'(tick), 0);
        chk("dis_duty", int'(duty), 0);
        chk("dis_dir",  int'(dir),  0);
        mhz(1);
        mhz(1);
        chk("reen_dir",  int'(dir),  1);
        chk("reen_duty", int'(duty), 0);
        wait_tick("reen");
        chk("reen_first_step", int'(duty), ST);

        // Prescaler stuck high: no edges, no ticks, everything freezes.
        tick_cyc.delete();
        repeat (60) cycle(1, 1);
        chk("stuck_ticks", tick_cyc.size(), 0);

        // PWM duty on the slow instance: duty 0 silent, then duty 4 = 64 of 256 clocks.
        repeat (3) mhz(0);
        mhz(1);
        cnt = 0;
        for (int k = 0; k < 300; k++) begin
            mhz(1);
            if (s_led) cnt++;
        end
        chk("pwm_duty0_high", cnt, 0);
        found = 0;
        for (int k = 0; k < 17000; k++) begin
            mhz(1);
            if (s_tick) begin
                found = 1;
                break;
            end
        end
        chk("slow_tick_seen", int'(found), 1);
        chk("slow_duty", int'(s_duty), ST);
        chk("slow_dir",  int'(s_dir),  1);
        repeat (4) mhz(1);
        cnt = 0;
        for (int k = 0; k < 256; k++) begin
            mhz(1);
            if (s_led) cnt++;
        end
        chk("pwm_duty4_high", cnt, 64);

        // Randomised prescaler activity and enable drops against the model.
        for (int k = 0; k < 2500; k++) begin
            if ((k / 500) % 2 == 0) p = ($urandom_range(0, 1) == 1);
            else                    p = ((ph % 16) < 8);
            ph++;
            cycle(p, ($urandom_range(0, 63) != 0));
        end

        // Asynchronous reset mid-ramp.
        for (int k = 0; k < 400; k++) begin
            mhz(1);
            if (exp_duty() != 0 && k > 100) break;
        end
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("arst_led",   int'(led),  0);
        chk("arst_tick",  int'(tick), 0);
        chk("arst_duty",  int'(duty), 0);
        chk("arst_dir",   int'(dir),  0);
        chk("arst_state", int'(u_dut.r_state), 0);
        presc = 1'b0;
        en    = 1'b0;
        model_reset();
        repeat (3) cycle(0, 0);
        rstn = 1'b1;
        repeat (2) mhz(1);
        repeat (100) mhz(1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
